// File: rtl/dropout_pkg.sv
// Shared constants and helpers for the dropout stream unit.
package dropout_pkg;

    localparam logic        MODE_BYPASS  = 1'b0;
    localparam logic        MODE_DROP    = 1'b1;
    localparam logic [15:0] LFSR16_TAPS  = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    function automatic logic [4:0] popcount(input logic [15:0] v);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < 16; i++) begin
            n = n + {4'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/dropout_stream_unit_lfsr.sv
// Galois right-shift LFSR with seed load; load wins over advance, and a zero seed
// falls back to SEED so the lock-up state is never entered.
module lfsr_galois
    import dropout_pkg::*;
#(
    parameter int             W    = 16,
    parameter logic [W-1:0]   TAPS = W'(LFSR16_TAPS),
    parameter logic [W-1:0]   SEED = W'(DEFAULT_SEED)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] state
);

    logic [W-1:0] state_q, state_d;

    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = (load_val == '0) ? SEED : load_val;
        end else if (en) begin
            state_d = (state_q >> 1) ^ (state_q[0] ? TAPS : '0);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= SEED;
        else        state_q <= state_d;
    end

    assign state = state_q;

endmodule

// File: rtl/dropout_stream_unit.sv
// LFSR-driven per-lane dropout on a valid/ready stream with one output register
// stage and a saturating count of dropped lanes.
module dropout_stream_unit
    import dropout_pkg::*;
#(
    parameter int                LANES  = 8,
    parameter int                LFSR_W = 16,
    parameter int                PROB_W = 8,
    parameter logic [LFSR_W-1:0] SEED   = LFSR_W'(DEFAULT_SEED),
    parameter int                CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              cfg_mode,
    input  logic [PROB_W-1:0] cfg_prob,
    input  logic              seed_load,
    input  logic [LFSR_W-1:0] seed_val,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [LANES-1:0]  in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [LANES-1:0]  out_data,
    output logic [LANES-1:0]  out_mask,
    output logic [CNT_W-1:0]  drop_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [LFSR_W-1:0] lfsr;
    logic              accept;
    logic [LANES-1:0]  lane_mask, drop_lanes;
    logic [4:0]        drops;
    logic [CNT_W+4:0]  cnt_sum;

    logic              out_valid_q, out_valid_d;
    logic [LANES-1:0]  out_data_q, out_data_d;
    logic [LANES-1:0]  out_mask_q, out_mask_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    function automatic logic [PROB_W-1:0] lane_slice(input logic [LFSR_W-1:0] x, input int n);
        logic [LFSR_W-1:0] r;
        r = (x << n) | (x >> (LFSR_W - n));
        return r[PROB_W-1:0];
    endfunction

    assign in_ready = rst_n & ena & ~seed_load & (~out_valid_q | out_ready);
    assign accept   = in_valid & in_ready;

    lfsr_galois #(
        .W    (LFSR_W),
        .TAPS (LFSR_W'(LFSR16_TAPS)),
        .SEED (SEED)
    ) u_lfsr (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (accept & (cfg_mode == MODE_DROP)),
        .load     (ena & seed_load),
        .load_val (seed_val),
        .state    (lfsr)
    );

    always_comb begin
        lane_mask = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_mask[i] = (cfg_mode == MODE_BYPASS) || (lane_slice(lfsr, i) >= cfg_prob);
        end
    end

    // Headroom of 5 extra bits covers up to 16 drops added to a full counter.
    assign drop_lanes = ~lane_mask;
    assign drops      = popcount(16'(drop_lanes));
    assign cnt_sum    = {5'd0, cnt_q} + (CNT_W+5)'(drops);

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_mask_d  = out_mask_q;
        cnt_d       = cnt_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = in_data & lane_mask;
            out_mask_d  = lane_mask;
            cnt_d       = (cnt_sum > (CNT_W+5)'(CNT_MAX)) ? CNT_MAX : cnt_sum[CNT_W-1:0];
        end else if (ena && out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_mask_q  <= '0;
            cnt_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_mask_q  <= out_mask_d;
            cnt_q       <= cnt_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_mask   = out_mask_q;
    assign drop_count = cnt_q;

endmodule

// File: tb/tb_dropout_stream_unit.sv
// Randomized bench for dropout_stream_unit against a behavioural stream model;
// a second instance with a 4-bit counter exercises saturation.
module tb_dropout_stream_unit;

    logic        clk = 1'b0;
    logic        rst_n, ena, cfg_mode, seed_load, in_valid, out_ready;
    logic [7:0]  cfg_prob, in_data;
    logic [15:0] seed_val;

    logic        in_ready, out_valid, in_ready_s, out_valid_s;
    logic [7:0]  out_data, out_mask, out_data_s, out_mask_s;
    logic [15:0] drop_count;
    logic [3:0]  drop_count_s;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] m_lfsr;
    logic        m_ov;
    logic [7:0]  m_data, m_mask;
    int          m_cnt, m_cnt4;

    always #5 clk = ~clk;

    dropout_stream_unit dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .cfg_mode(cfg_mode), .cfg_prob(cfg_prob),
        .seed_load(seed_load), .seed_val(seed_val), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_mask(out_mask), .drop_count(drop_count)
    );

    dropout_stream_unit #(.CNT_W(4)) dut_s (
        .clk(clk), .rst_n(rst_n), .ena(ena), .cfg_mode(cfg_mode), .cfg_prob(cfg_prob),
        .seed_load(seed_load), .seed_val(seed_val), .in_valid(in_valid), .in_ready(in_ready_s),
        .in_data(in_data), .out_valid(out_valid_s), .out_ready(out_ready), .out_data(out_data_s),
        .out_mask(out_mask_s), .drop_count(drop_count_s)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Lane i keeps its bit when the low byte of the state rotated left by i reaches prob.
    function automatic logic [7:0] ref_mask(input logic [15:0] st, input logic mode, input logic [7:0] prob);
        logic [31:0] d;
        logic [7:0]  m;
        d = {st, st};
        for (int i = 0; i < 8; i++) begin
            m[i] = !mode || (8'(d >> (16 - i)) >= prob);
        end
        return m;
    endfunction

    function automatic logic [15:0] ref_next(input logic [15:0] st);
        return st[0] ? ((st >> 1) ^ 16'hB400) : (st >> 1);
    endfunction

    task automatic cyc();
        logic       rdy, acc;
        logic [7:0] mk;
        int         drops;
        #1;
        rdy = rst_n && ena && !seed_load && (!m_ov || out_ready);
        chk("in_ready", in_ready, rdy);
        chk("in_ready_s", in_ready_s, rdy);
        acc = in_valid && rdy;
        @(posedge clk);
        if (!rst_n) begin
            m_lfsr = 16'hACE1; m_ov = 0; m_data = 0; m_mask = 0; m_cnt = 0; m_cnt4 = 0;
        end else if (ena) begin
            if (acc) begin
                mk = ref_mask(m_lfsr, cfg_mode, cfg_prob);
                drops = 0;
                for (int i = 0; i < 8; i++) if (!mk[i]) drops++;
                m_mask = mk;
                m_data = in_data & mk;
                m_ov   = 1;
                m_cnt  = (m_cnt + drops > 65535) ? 65535 : m_cnt + drops;
                m_cnt4 = (m_cnt4 + drops > 15) ? 15 : m_cnt4 + drops;
            end else if (m_ov && out_ready) begin
                m_ov = 0;
            end
            if (seed_load)          m_lfsr = (seed_val == 0) ? 16'hACE1 : seed_val;
            else if (acc && cfg_mode) m_lfsr = ref_next(m_lfsr);
        end
        #1;
        chk("out_valid", out_valid, m_ov);
        chk("out_data", out_data, m_data);
        chk("out_mask", out_mask, m_mask);
        chk("drop_count", drop_count, m_cnt);
        chk("out_valid_s", out_valid_s, m_ov);
        chk("out_mask_s", out_mask_s, m_mask);
        chk("drop_count_s", drop_count_s, m_cnt4);
    endtask

    logic [7:0] saved, rec [6];
    logic [3:0] saved_cnt;

    initial begin
        m_lfsr = 16'hACE1; m_ov = 0; m_data = 0; m_mask = 0; m_cnt = 0; m_cnt4 = 0;
        rst_n = 0; ena = 1; in_valid = 1; in_data = 8'h3C; cfg_mode = 1; cfg_prob = 8'd128;
        seed_load = 0; seed_val = 16'h0; out_ready = 1;

        // Reset with a pending beat
        repeat (2) cyc();
        chk("rst_valid", out_valid, 0);
        chk("rst_count", drop_count, 0);

        // Bypass: first beat after release, LFSR must not move
        rst_n = 1; cfg_mode = 0; cfg_prob = 8'hFF; in_data = 8'hA5;
        repeat (6) cyc();
        chk("byp_data", out_data, 8'hA5);
        chk("byp_mask", out_mask, 8'hFF);
        chk("byp_count", drop_count, 0);

        // Known sequence from seed ACE1
        cfg_mode = 1; cfg_prob = 8'd128; in_data = 8'hFF;
        cyc();
        chk("known_b1_lane0", out_mask[0], 1);
        cyc();
        chk("known_b2_lane0", out_mask[0], 0);
        in_valid = 0;
        cyc();

        // Backpressure
        out_ready = 0; in_valid = 1; in_data = 8'h5A;
        cyc();
        saved = out_data;
        in_data = 8'hC3;
        repeat (4) cyc();
        chk("bp_stable", out_data, saved);
        out_ready = 1;
        cyc();

        // Seed reload replay
        for (int pass = 0; pass < 2; pass++) begin
            seed_load = 1; seed_val = 16'h0; in_valid = 1;
            cyc();
            seed_load = 0;
            for (int k = 0; k < 6; k++) begin
                in_data = 8'hFF;
                cyc();
                if (pass == 0) rec[k] = out_mask;
                else           chk("replay_mask", out_mask, rec[k]);
            end
        end

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            rst_n     = ($urandom % 100) != 0;
            ena       = ($urandom % 8) != 0;
            seed_load = ($urandom % 16) == 0;
            seed_val  = (($urandom % 4) == 0) ? 16'h0 : 16'($urandom);
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 3) != 0;
            cfg_mode  = ($urandom % 4) != 0;
            cfg_prob  = 8'($urandom);
            in_data   = 8'($urandom);
            cyc();
        end

        // Saturation and freeze
        rst_n = 0; ena = 1; seed_load = 0; in_valid = 1; out_ready = 1;
        cfg_mode = 1; cfg_prob = 8'hFF; in_data = 8'hFF;
        cyc();
        rst_n = 1;
        repeat (3) cyc();
        ena = 0;
        saved_cnt = drop_count_s;
        repeat (3) cyc();
        chk("freeze_valid", out_valid_s, 1);
        chk("freeze_count", drop_count_s, saved_cnt);
        ena = 1;
        repeat (3) cyc();
        chk("sat15", drop_count_s, 4'd15);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
